// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the RV32 pipeline hazard-control block.
//   XLEN      : data / PC width
//   FWD_*     : forwarding-select codes driven on forwardAE / forwardBE
//   REG_ZERO  : architectural register x0, never a real producer
package pipeline_hazard_ctrl_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [1:0] FWD_E = 2'b00;  // operand latched in E
   localparam logic [1:0] FWD_W = 2'b01;  // writeback result
   localparam logic [1:0] FWD_M = 2'b10;  // ALU result in M

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_mux3.sv
// 3:1 operand mux for E-stage forwarding.
//   sel_i  : forwarding select (FWD_E / FWD_W / FWD_M; 2'b11 falls back to src_i)
//   src_i  : register-file operand latched in E
//   wb_i   : writeback result
//   mem_i  : ALU result in M
//   y_o    : selected operand
module fwd_mux3
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [1:0]       sel_i,
   input  logic [WIDTH-1:0] src_i,
   input  logic [WIDTH-1:0] wb_i,
   input  logic [WIDTH-1:0] mem_i,
   output logic [WIDTH-1:0] y_o
);

   always_comb begin
      y_o = src_i;
      case (sel_i)
         FWD_W:   y_o = wb_i;
         FWD_M:   y_o = mem_i;
         default: y_o = src_i;
      endcase
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard control for the 5-stage RV32 pipeline (F/D/E/M/W).
//   clk, reset            : clock and synchronous active-high reset (PC register only)
//   pcnext / pc           : next-PC candidate in, current fetch PC out
//   rs1D, rs2D            : sources of the instruction in D
//   rs1E, rs2E, rdE       : sources / destination of the instruction in E
//   memtoregE             : instruction in E is a load
//   rdM, rdW, writesreg*  : destinations and write enables in M and W
//   speculative{E,M,W}    : taken jump/branch present in E, M or W
//   srcaE, srcbE          : register-file operands in E
//   aluoutM, resultW      : forwarding sources
//   stallF, stallD        : hold PC and F/D register
//   flushE                : bubble into D/E register
//   forwardAE, forwardBE  : forwarding selects
//   srcaFwd, srcbFwd      : forwarded E operands
module pipeline_hazard_ctrl #(
   parameter int unsigned      XLEN     = 32,
   parameter logic [XLEN-1:0]  RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] pcnext,
   output logic [XLEN-1:0] pc,
   input  logic [4:0]      rs1D,
   input  logic [4:0]      rs2D,
   input  logic [4:0]      rs1E,
   input  logic [4:0]      rs2E,
   input  logic [4:0]      rdE,
   input  logic            memtoregE,
   input  logic [4:0]      rdM,
   input  logic [4:0]      rdW,
   input  logic            writesregM,
   input  logic            writesregW,
   input  logic            speculativeE,
   input  logic            speculativeM,
   input  logic            speculativeW,
   input  logic [XLEN-1:0] srcaE,
   input  logic [XLEN-1:0] srcbE,
   input  logic [XLEN-1:0] aluoutM,
   input  logic [XLEN-1:0] resultW,
   output logic            stallF,
   output logic            stallD,
   output logic            flushE,
   output logic [1:0]      forwardAE,
   output logic [1:0]      forwardBE,
   output logic [XLEN-1:0] srcaFwd,
   output logic [XLEN-1:0] srcbFwd
);

   import pipeline_hazard_ctrl_pkg::*;

   logic            spec_any;
   logic            lwstall;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_d;

   // Forwarding selects: M is the younger producer, so it is checked first.
   always_comb begin
      forwardAE = FWD_E;
      if (rs1E != REG_ZERO && writesregM && rs1E == rdM)
         forwardAE = FWD_M;
      else if (rs1E != REG_ZERO && writesregW && rs1E == rdW)
         forwardAE = FWD_W;

      forwardBE = FWD_E;
      if (rs2E != REG_ZERO && writesregM && rs2E == rdM)
         forwardBE = FWD_M;
      else if (rs2E != REG_ZERO && writesregW && rs2E == rdW)
         forwardBE = FWD_W;
   end

   fwd_mux3 #(.WIDTH(XLEN)) u_fwd_a (
      .sel_i (forwardAE),
      .src_i (srcaE),
      .wb_i  (resultW),
      .mem_i (aluoutM),
      .y_o   (srcaFwd)
   );

   fwd_mux3 #(.WIDTH(XLEN)) u_fwd_b (
      .sel_i (forwardBE),
      .src_i (srcbE),
      .wb_i  (resultW),
      .mem_i (aluoutM),
      .y_o   (srcbFwd)
   );

   // A taken branch anywhere in E..W means the instruction in D is wrong-path
   // and will be flushed anyway, so a load-use stall on it is suppressed to let
   // the redirect from M reach the PC.
   always_comb begin
      spec_any = speculativeE | speculativeM | speculativeW;
      lwstall  = memtoregE && (rdE != REG_ZERO) &&
                 ((rdE == rs1D) || (rdE == rs2D)) && !spec_any;
      stallF   = lwstall;
      stallD   = lwstall;
      flushE   = lwstall | spec_any;
   end

   always_comb begin
      pc_d = stallF ? pc_q : pcnext;
   end

   always_ff @(posedge clk) begin
      if (reset)
         pc_q <= RESET_PC;
      else
         pc_q <= pc_d;
   end

   assign pc = pc_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed by
// randomized stimulus compared against a behavioural reference model.
module tb_pipeline_hazard_ctrl;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        reset;
   logic [31:0] pcnext, pc;
   logic [4:0]  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
   logic        memtoregE, writesregM, writesregW;
   logic        speculativeE, speculativeM, speculativeW;
   logic [31:0] srcaE, srcbE, aluoutM, resultW;
   logic        stallF, stallD, flushE;
   logic [1:0]  forwardAE, forwardBE;
   logic [31:0] srcaFwd, srcbFwd;

   int unsigned n_total;
   int unsigned n_pass;
   logic [31:0] exp_pc;

   pipeline_hazard_ctrl #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
      .clk          (clk),
      .reset        (reset),
      .pcnext       (pcnext),
      .pc           (pc),
      .rs1D         (rs1D),
      .rs2D         (rs2D),
      .rs1E         (rs1E),
      .rs2E         (rs2E),
      .rdE          (rdE),
      .memtoregE    (memtoregE),
      .rdM          (rdM),
      .rdW          (rdW),
      .writesregM   (writesregM),
      .writesregW   (writesregW),
      .speculativeE (speculativeE),
      .speculativeM (speculativeM),
      .speculativeW (speculativeW),
      .srcaE        (srcaE),
      .srcbE        (srcbE),
      .aluoutM      (aluoutM),
      .resultW      (resultW),
      .stallF       (stallF),
      .stallD       (stallD),
      .flushE       (flushE),
      .forwardAE    (forwardAE),
      .forwardBE    (forwardBE),
      .srcaFwd      (srcaFwd),
      .srcbFwd      (srcbFwd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp)
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      else
         n_pass++;
   endtask

   // ---------------- reference model ----------------
   // Producers listed youngest first; the first valid one whose destination
   // equals the (non-x0) source wins.
   function automatic logic [1:0] ref_sel(input logic [4:0] rs);
      logic [4:0] prod_rd [2];
      logic       prod_v  [2];
      logic [1:0] prod_c  [2];
      prod_rd[0] = rdM; prod_v[0] = writesregM; prod_c[0] = 2'b10;
      prod_rd[1] = rdW; prod_v[1] = writesregW; prod_c[1] = 2'b01;
      if (rs == 5'd0) return 2'b00;
      for (int i = 0; i < 2; i++)
         if (prod_v[i] && prod_rd[i] == rs) return prod_c[i];
      return 2'b00;
   endfunction

   function automatic logic [31:0] ref_val(input logic [1:0] sel, input logic [31:0] own);
      if (sel == 2'b10) return aluoutM;
      if (sel == 2'b01) return resultW;
      return own;
   endfunction

   function automatic logic ref_branch();
      return speculativeE || speculativeM || speculativeW;
   endfunction

   function automatic logic ref_stall();
      logic uses;
      uses = (rdE == rs1D) || (rdE == rs2D);
      return memtoregE && rdE != 5'd0 && uses && !ref_branch();
   endfunction

   task automatic check_comb(input string tag);
      logic [1:0] sa, sb;
      #1;
      sa = ref_sel(rs1E);
      sb = ref_sel(rs2E);
      check({tag, ".fwdA"},   {30'd0, forwardAE}, {30'd0, sa});
      check({tag, ".fwdB"},   {30'd0, forwardBE}, {30'd0, sb});
      check({tag, ".srcaF"},  srcaFwd, ref_val(sa, srcaE));
      check({tag, ".srcbF"},  srcbFwd, ref_val(sb, srcbE));
      check({tag, ".stallF"}, {31'd0, stallF}, {31'd0, ref_stall()});
      check({tag, ".stallD"}, {31'd0, stallD}, {31'd0, ref_stall()});
      check({tag, ".flushE"}, {31'd0, flushE}, {31'd0, ref_stall() | ref_branch()});
   endtask

   task automatic tick(input string tag);
      logic [31:0] nxt;
      if (reset)            nxt = RESET_PC;
      else if (ref_stall()) nxt = exp_pc;
      else                  nxt = pcnext;
      @(posedge clk);
      #1;
      exp_pc = nxt;
      check({tag, ".pc"}, pc, exp_pc);
   endtask

   task automatic clear_inputs();
      reset = 1'b0; pcnext = '0;
      rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0; rdE = '0; rdM = '0; rdW = '0;
      memtoregE = 1'b0; writesregM = 1'b0; writesregW = 1'b0;
      speculativeE = 1'b0; speculativeM = 1'b0; speculativeW = 1'b0;
      srcaE = 32'hAAAA_0001; srcbE = 32'hBBBB_0002; aluoutM = '0; resultW = '0;
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      exp_pc  = RESET_PC;
      clear_inputs();

      // Reset behaviour
      reset = 1'b1; pcnext = 32'h40;
      tick("rst");
      check("rst.pc0", pc, 32'h0);
      reset = 1'b0;
      tick("rel");
      check("rel.pc40", pc, 32'h40);
      memtoregE = 1'b1; rdE = 5'd3; rs2D = 5'd3; reset = 1'b1; pcnext = 32'h80;
      tick("rststall");
      check("rststall.pc0", pc, 32'h0);
      clear_inputs();
      pcnext = 32'h40;
      tick("adv");

      // Forwarding priority
      rs1E = 5'd5; rdM = 5'd5; writesregM = 1'b1; rdW = 5'd5; writesregW = 1'b1;
      aluoutM = 32'h11; resultW = 32'h22;
      check_comb("prioM");
      check("prioM.fwdA10", {30'd0, forwardAE}, 32'h2);
      check("prioM.val", srcaFwd, 32'h11);
      writesregM = 1'b0;
      check_comb("prioW");
      check("prioW.fwdA01", {30'd0, forwardAE}, 32'h1);
      check("prioW.val", srcaFwd, 32'h22);

      // x0 guard and no-match
      clear_inputs();
      rs2E = 5'd0; rdM = 5'd0; writesregM = 1'b1; aluoutM = 32'h55;
      check_comb("x0");
      check("x0.srcb", srcbFwd, 32'hBBBB_0002);
      rs2E = 5'd7; rdM = 5'd6; rdW = 5'd8; writesregW = 1'b1;
      check_comb("nomatch");

      // Load-use stall: pc holds while pcnext changes
      clear_inputs();
      pcnext = 32'h100;
      tick("pre_lu");
      memtoregE = 1'b1; rdE = 5'd3; rs2D = 5'd3; pcnext = 32'h104;
      check_comb("lu");
      check("lu.stallF1", {31'd0, stallF}, 32'h1);
      tick("lu");
      check("lu.hold", pc, 32'h100);
      memtoregE = 1'b0;
      check_comb("nolu");
      tick("nolu");
      check("nolu.adv", pc, 32'h104);

      // Control hazard: branch walks E, M, W
      speculativeE = 1'b1; pcnext = 32'h108;
      check_comb("specE");
      tick("specE");
      speculativeE = 1'b0; speculativeM = 1'b1; pcnext = 32'h200;
      check_comb("specM");
      check("specM.flush", {31'd0, flushE}, 32'h1);
      tick("specM");
      check("specM.redirect", pc, 32'h200);
      speculativeM = 1'b0; speculativeW = 1'b1; pcnext = 32'h204;
      check_comb("specW");
      tick("specW");

      // Simultaneous load-use and redirect: redirect wins
      clear_inputs();
      memtoregE = 1'b1; rdE = 5'd3; rs1D = 5'd3; speculativeM = 1'b1; pcnext = 32'h300;
      check_comb("simul");
      check("simul.stall0", {31'd0, stallF}, 32'h0);
      tick("simul");
      check("simul.pc", pc, 32'h300);

      // Randomized stimulus, small register range to raise hit rate
      for (int i = 0; i < 400; i++) begin
         reset        = ($urandom_range(0, 29) == 0);
         pcnext       = $urandom;
         rs1D         = 5'($urandom_range(0, 7));
         rs2D         = 5'($urandom_range(0, 7));
         rs1E         = 5'($urandom_range(0, 7));
         rs2E         = 5'($urandom_range(0, 7));
         rdE          = 5'($urandom_range(0, 7));
         rdM          = 5'($urandom_range(0, 7));
         rdW          = 5'($urandom_range(0, 7));
         memtoregE    = 1'($urandom_range(0, 1));
         writesregM   = 1'($urandom_range(0, 1));
         writesregW   = 1'($urandom_range(0, 1));
         speculativeE = ($urandom_range(0, 5) == 0);
         speculativeM = ($urandom_range(0, 5) == 0);
         speculativeW = ($urandom_range(0, 5) == 0);
         srcaE        = $urandom;
         srcbE        = $urandom;
         aluoutM      = $urandom;
         resultW      = $urandom;
         check_comb("rnd");
         tick("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Hazard-control block for the 5-stage RV32 pipeline (F/D/E/M/W).
- Contains operand forwarding selection and the two E-stage forwarding muxes.
- Detects load-use stalls and flushes for control hazards. A branch resolves in E and redirects the PC from M.
- Holds the architectural PC register; the register is gated by the fetch stall.

Parameters:
- XLEN, 32, data/PC width.
- RESET_PC, 32'h0000_0000, PC value after reset.

Ports:
- clk  in  1  clock; only the PC register uses it.
- reset  in  1  synchronous, active-high reset.
- pcnext  in  XLEN  next-PC candidate (pc+4 or redirect target from M).
- pc  out  XLEN  current fetch PC.
- rs1D, rs2D  in  5 each  source registers of the instruction in D.
- rs1E, rs2E, rdE  in  5 each  sources and destination of the instruction in E.
- memtoregE  in  1  instruction in E is a load.
- rdM, rdW  in  5 each  destination registers in M and W.
- writesregM, writesregW  in  1 each  M/W instruction writes the register file.
- speculativeE, speculativeM, speculativeW  in  1 each  taken jump/branch currently in E, M or W.
- srcaE, srcbE  in  XLEN each  register-file operands latched in E.
- aluoutM  in  XLEN  ALU result in M.
- resultW  in  XLEN  writeback result.
- stallF, stallD  out  1 each  hold the PC and the F/D pipe register.
- flushE  out  1  clear the D/E pipe register (insert a bubble).
- forwardAE, forwardBE  out  2 each  forwarding selects.
- srcaFwd, srcbFwd  out  XLEN each  forwarded E operands.

Behaviour:
- All outputs except pc are purely combinational. They are not affected by reset.
- Forward select encoding: 2'b00 = srcE (no forward), 2'b10 = aluoutM, 2'b01 = resultW, 2'b11 = srcE.
- forwardAE rule, in priority order:
  - 2'b10 if rs1E!=0 && writesregM && rs1E==rdM;
  - else 2'b01 if rs1E!=0 && writesregW && rs1E==rdW;
  - else 2'b00.
- forwardBE: same rule using rs2E.
- M has priority over W when both match.
- srcaFwd = mux(forwardAE; srcaE, aluoutM, resultW). srcbFwd = mux(forwardBE; srcbE, aluoutM, resultW).
- specAny = speculativeE | speculativeM | speculativeW.
- lwstall = memtoregE && rdE!=0 && (rdE==rs1D || rdE==rs2D) && !specAny.
- stallF = stallD = lwstall.
- flushE = lwstall | specAny. This squashes the three wrong-path instructions that enter E during the cycles the branch is in E, M and W.
- PC register:
  - Posedge clk, synchronous reset: if reset, pc <= RESET_PC.
  - Else if !stallF, pc <= pcnext.
  - Else pc holds.
- Reset has priority over the stall.
- Register x0 never triggers forwarding or a stall.

Decomposition:
- Shared package holds:
  - XLEN;
  - forward-select constants FWD_E=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - REG_ZERO=5'd0.
- One natural sub-module, fwd_mux3: 3:1 XLEN mux with a 2-bit select. Instantiate it twice.
- The hazard logic and the PC register stay inline.

Test Plan:
- Reset: assert reset one cycle with pcnext=32'h40 → pc=0. Release with pcnext=32'h40 → pc=32'h40 next edge. Assert reset with stall active → pc=0.
- Forwarding priority: rs1E=5, rdM=5, writesregM=1, rdW=5, writesregW=1, aluoutM=0x11, resultW=0x22 → forwardAE=10, srcaFwd=0x11. Set writesregM=0 → forwardAE=01, srcaFwd=0x22.
- x0 guard and no-match:
  - rs2E=0, rdM=0, writesregM=1 → forwardBE=00, srcbFwd=srcbE.
  - rs2E=7, rdM=6, rdW=8 → forwardBE=00.
- Load-use: memtoregE=1, rdE=3, rs2D=3 → stallF=stallD=flushE=1, and pc holds its value across the edge with pcnext changing. With memtoregE=0 → all 0 and pc advances.
- Control hazard: pulse speculativeE, then speculativeM, then speculativeW on consecutive cycles → flushE=1 each cycle, stallF=0. pc loads pcnext=target at the edge while speculativeM=1.
- Simultaneous events: memtoregE=1, rdE=3, rs1D=3, speculativeM=1 → stallF=0, flushE=1, and pc loads pcnext.
